// File: rtl/cpu_pkg.sv
// Shared CPU definitions: status-register bit positions, flag instruction
// encodings and the architectural reset image of P.
package cpu_pkg;

   // Bit positions inside the status register P (N V - B D I Z C).
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_I = 2;
   localparam int FLAG_D = 3;
   localparam int FLAG_B = 4;
   localparam int FLAG_U = 5;
   localparam int FLAG_V = 6;
   localparam int FLAG_N = 7;

   // Explicit flag instructions decoded upstream.
   typedef enum logic [2:0] {
      FOP_NONE = 3'd0,
      FOP_CLC  = 3'd1,
      FOP_SEC  = 3'd2,
      FOP_CLI  = 3'd3,
      FOP_SEI  = 3'd4,
      FOP_CLD  = 3'd5,
      FOP_SED  = 3'd6,
      FOP_CLV  = 3'd7
   } flag_op_e;

   // P as seen right after reset with the I flag set: only bit5 and I are 1.
   localparam logic [7:0] P_RESET = 8'h24;

endpackage

// File: rtl/alu_status_reg.sv
// Registered back end of the 6502 ALU: ADD hold register plus the status
// register P. Six flags are stored; B and bit5 exist only in the read images.
module alu_status_reg
   import cpu_pkg::*;
#(
   parameter logic I_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_ovflw,
   input  logic [7:0] mem_data,
   input  logic       add_load,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       bit_test,
   input  logic [2:0] flag_op,
   input  logic       plp,
   input  logic       irq_entry,
   input  logic       brk_push,
   output logic [7:0] add_out,
   output logic [7:0] p_out,
   output logic [7:0] p_push,
   output logic       carry_flag,
   output logic       dec_flag,
   output logic       irq_mask
);

   logic [7:0] add_q;
   logic       n_q, v_q, d_q, i_q, z_q, c_q;
   logic       n_d, v_d, d_d, i_d, z_d, c_d;
   logic       res_zero;
   flag_op_e   fop;

   assign fop      = flag_op_e'(flag_op);
   assign res_zero = ~|alu_result;

   // Per-flag next state; each chain lists its sources highest priority first.
   always_comb begin
      // NOTE: every output of a combinational block gets a default on entry so no path leaves it unassigned and a latch is never inferred.
      n_d = n_q;
      v_d = v_q;
      d_d = d_q;
      i_d = i_q;
      z_d = z_q;
      c_d = c_q;

      // Carry: PLP, then CLC/SEC, then the ALU carry out.
      if (plp)                c_d = mem_data[FLAG_C];
      else if (fop == FOP_CLC) c_d = 1'b0;
      else if (fop == FOP_SEC) c_d = 1'b1;
      else if (upd_c)         c_d = alu_carry;

      // Zero: PLP, then BIT (A AND M arrives on alu_result), then normal results.
      if (plp)                     z_d = mem_data[FLAG_Z];
      else if (bit_test || upd_nz) z_d = res_zero;

      // Negative: BIT takes the memory operand's bit 7 rather than the result's.
      if (plp)           n_d = mem_data[FLAG_N];
      else if (bit_test) n_d = mem_data[7];
      else if (upd_nz)   n_d = alu_result[7];

      // Overflow: CLV outranks BIT, which outranks the ALU overflow.
      if (plp)                v_d = mem_data[FLAG_V];
      else if (fop == FOP_CLV) v_d = 1'b0;
      else if (bit_test)      v_d = mem_data[6];
      else if (upd_v)         v_d = alu_ovflw;

      // Decimal: only PLP and CLD/SED touch it.
      if (plp)                d_d = mem_data[FLAG_D];
      else if (fop == FOP_CLD) d_d = 1'b0;
      else if (fop == FOP_SED) d_d = 1'b1;

      // Interrupt mask: interrupt entry wins over everything, even PLP.
      if (irq_entry)          i_d = 1'b1;
      else if (plp)           i_d = mem_data[FLAG_I];
      else if (fop == FOP_CLI) i_d = 1'b0;
      else if (fop == FOP_SEI) i_d = 1'b1;
   end

   // ADD hold register, loaded independently of the flag logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_q <= 8'h00;
      end else if (add_load) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
         add_q <= alu_result;
      end
   end

   // Status flag flops with asynchronous reset to the architectural state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= 1'b0;
         v_q <= 1'b0;
         d_q <= 1'b0;
         i_q <= I_RESET;
         z_q <= 1'b0;
         c_q <= 1'b0;
      end else begin
         n_q <= n_d;
         v_q <= v_d;
         d_q <= d_d;
         i_q <= i_d;
         z_q <= z_d;
         c_q <= c_d;
      end
   end

   // Read images of P: bit5 always 1, B is 0 in p_out and brk_push in p_push.
   always_comb begin
      p_out         = 8'h00;
      p_out[FLAG_N] = n_q;
      p_out[FLAG_V] = v_q;
      p_out[FLAG_U] = 1'b1;
      p_out[FLAG_B] = 1'b0;
      p_out[FLAG_D] = d_q;
      p_out[FLAG_I] = i_q;
      p_out[FLAG_Z] = z_q;
      p_out[FLAG_C] = c_q;

      p_push         = p_out;
      p_push[FLAG_B] = brk_push;
   end

   assign add_out    = add_q;
   assign carry_flag = c_q;
   assign dec_flag   = d_q;
   assign irq_mask   = i_q;

endmodule

// File: tb/tb_alu_status_reg.sv
// Self-checking bench for alu_status_reg: directed vector table, hand-written
// reset/push sequences and randomized traffic against a byte-level P model.
module tb_alu_status_reg;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] alu_result, mem_data;
   logic       alu_carry, alu_ovflw;
   logic       add_load, upd_nz, upd_c, upd_v, bit_test, plp, irq_entry, brk_push;
   logic [2:0] flag_op;
   logic [7:0] add_out, p_out, p_push;
   logic       carry_flag, dec_flag, irq_mask;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] res;
      logic       carry;
      logic       ovf;
      logic [7:0] mem;
      logic       add_load;
      logic       upd_nz;
      logic       upd_c;
      logic       upd_v;
      logic       bit_test;
      logic [2:0] fop;
      logic       plp;
      logic       irq;
      logic [7:0] exp_p;
      logic [7:0] exp_add;
   } vec_t;

   vec_t vecs[14];

   alu_status_reg #(.I_RESET(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovflw(alu_ovflw),
      .mem_data(mem_data), .add_load(add_load), .upd_nz(upd_nz),
      .upd_c(upd_c), .upd_v(upd_v), .bit_test(bit_test), .flag_op(flag_op),
      .plp(plp), .irq_entry(irq_entry), .brk_push(brk_push),
      .add_out(add_out), .p_out(p_out), .p_push(p_push),
      .carry_flag(carry_flag), .dec_flag(dec_flag), .irq_mask(irq_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      alu_result = v.res;
      alu_carry  = v.carry;
      alu_ovflw  = v.ovf;
      mem_data   = v.mem;
      add_load   = v.add_load;
      upd_nz     = v.upd_nz;
      upd_c      = v.upd_c;
      upd_v      = v.upd_v;
      bit_test   = v.bit_test;
      flag_op    = v.fop;
      plp        = v.plp;
      irq_entry  = v.irq;
   endtask

   task automatic idle();
      vec_t v;
      v = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00};
      drive(v);
   endtask

   task automatic randomize_inputs();
      vec_t v;
      v.res      = 8'($urandom);
      v.carry    = 1'($urandom);
      v.ovf      = 1'($urandom);
      v.mem      = 8'($urandom);
      v.add_load = ($urandom_range(3) == 0);
      v.upd_nz   = ($urandom_range(3) == 0);
      v.upd_c    = ($urandom_range(3) == 0);
      v.upd_v    = ($urandom_range(3) == 0);
      v.bit_test = ($urandom_range(5) == 0);
      v.fop      = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom);
      v.plp      = ($urandom_range(7) == 0);
      v.irq      = ($urandom_range(7) == 0);
      drive(v);
   endtask

   // Reference: start from the old byte and let each source overwrite in
   // increasing priority order, so the last writer is the winner.
   function automatic logic [7:0] model_p(input logic [7:0] p, input vec_t v);
      logic [7:0] q;
      logic       zero;
      q    = p;
      zero = (v.res == 8'd0);
      if (v.upd_nz) begin q[7] = v.res[7]; q[1] = zero; end
      if (v.upd_c) q[0] = v.carry;
      if (v.upd_v) q[6] = v.ovf;
      if (v.bit_test) begin q[7] = v.mem[7]; q[6] = v.mem[6]; q[1] = zero; end
      case (v.fop)
         3'd1: q[0] = 1'b0;
         3'd2: q[0] = 1'b1;
         3'd3: q[2] = 1'b0;
         3'd4: q[2] = 1'b1;
         3'd5: q[3] = 1'b0;
         3'd6: q[3] = 1'b1;
         3'd7: q[6] = 1'b0;
         default: ;
      endcase
      if (v.plp) q = v.mem;
      if (v.irq) q[2] = 1'b1;
      q[5] = 1'b1;
      q[4] = 1'b0;
      return q;
   endfunction

   function automatic vec_t sample_inputs();
      vec_t v;
      v = '{alu_result, alu_carry, alu_ovflw, mem_data, add_load, upd_nz, upd_c,
            upd_v, bit_test, flag_op, plp, irq_entry, 8'h00, 8'h00};
      return v;
   endfunction

   initial begin
      logic [7:0] m_p, m_add;
      vec_t cur;

      // Directed table, applied in order from the reset state.
      //            res    cy    ov    mem    ld nz c  v  bit fop   plp irq  p      add
      vecs[0]  = '{8'h80, 1'b0, 1'b1, 8'h00, 1, 1, 1, 1, 0, 3'd0, 0, 0, 8'hE4, 8'h80};
      vecs[1]  = '{8'h00, 1'b1, 1'b0, 8'h00, 0, 1, 1, 0, 0, 3'd0, 0, 0, 8'h67, 8'h80};
      vecs[2]  = '{8'h00, 1'b0, 1'b0, 8'hC0, 0, 1, 0, 0, 1, 3'd0, 0, 0, 8'hE7, 8'h80};
      vecs[3]  = '{8'h00, 1'b0, 1'b0, 8'hFF, 0, 0, 0, 0, 0, 3'd0, 1, 0, 8'hEF, 8'h80};
      vecs[4]  = '{8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 3'd0, 1, 1, 8'h24, 8'h80};
      vecs[5]  = '{8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0, 0, 3'd2, 0, 0, 8'h25, 8'h80};
      vecs[6]  = '{8'h01, 1'b0, 1'b0, 8'h40, 0, 0, 0, 0, 1, 3'd7, 0, 0, 8'h25, 8'h80};
      vecs[7]  = '{8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 3'd6, 0, 0, 8'h2D, 8'h80};
      vecs[8]  = '{8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 3'd3, 0, 0, 8'h29, 8'h80};
      vecs[9]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1, 1, 0, 0, 0, 3'd0, 0, 0, 8'h2B, 8'h00};
      vecs[10] = '{8'h00, 1'b1, 1'b0, 8'h00, 0, 0, 1, 0, 0, 3'd1, 0, 0, 8'h2A, 8'h00};
      vecs[11] = '{8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 3'd4, 0, 0, 8'h2E, 8'h00};
      vecs[12] = '{8'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 3'd5, 0, 0, 8'h26, 8'h00};
      vecs[13] = '{8'h00, 1'b0, 1'b1, 8'h00, 0, 0, 0, 1, 0, 3'd0, 0, 0, 8'h66, 8'h00};

      // Reset held low with random inputs.
      rst_n    = 1'b0;
      brk_push = 1'b0;
      randomize_inputs();
      repeat (3) begin
         @(posedge clk); #1;
         randomize_inputs();
      end
      check("reset_p_out", p_out, P_RESET);
      check("reset_add_out", add_out, 8'h00);
      check("reset_carry", {7'd0, carry_flag}, 8'h00);
      check("reset_dec", {7'd0, dec_flag}, 8'h00);
      check("reset_irq_mask", {7'd0, irq_mask}, 8'h01);

      // Release with idle strobes; state must not move.
      idle();
      #2 rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("idle_p_out", p_out, 8'h24);
         check("idle_add_out", add_out, 8'h00);
      end

      // Push image follows brk_push combinationally.
      brk_push = 1'b1; #1;
      check("push_brk1", p_push, 8'h34);
      brk_push = 1'b0; #1;
      check("push_brk0", p_push, 8'h24);

      // Directed table.
      for (int k = 0; k < 14; k++) begin
         drive(vecs[k]);
         @(posedge clk); #1;
         check($sformatf("vec%0d_p_out", k), p_out, vecs[k].exp_p);
         check($sformatf("vec%0d_add_out", k), add_out, vecs[k].exp_add);
      end

      // Async reset between edges after loading P=0xEF.
      cur = '{8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00};
      drive(cur);
      @(posedge clk); #1;
      idle();
      check("async_pre_p_out", p_out, 8'hEF);
      #2 rst_n = 1'b0;
      #1;
      check("async_p_out", p_out, 8'h24);
      check("async_add_out", add_out, 8'h00);
      check("async_carry", {7'd0, carry_flag}, 8'h00);
      #1 rst_n = 1'b1;

      // A held strobe re-applied each cycle gives the same result.
      cur = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 8'h00};
      drive(cur);
      repeat (3) @(posedge clk);
      #1;
      check("held_sed_dec", {7'd0, dec_flag}, 8'h01);
      check("held_sed_p_out", p_out, 8'h2C);

      // Randomized traffic against the byte-level model.
      m_p   = p_out == 8'h2C ? 8'h2C : 8'h2C;
      m_add = 8'h00;
      for (int k = 0; k < 400; k++) begin
         randomize_inputs();
         brk_push = 1'($urandom);
         #1;
         cur = sample_inputs();
         check("rnd_p_push", p_push, {m_p[7:5], brk_push, m_p[3:0]});
         m_p = model_p(m_p, cur);
         if (cur.add_load) m_add = cur.res;
         @(posedge clk); #1;
         check("rnd_p_out", p_out, m_p);
         check("rnd_add_out", add_out, m_add);
         check("rnd_flags", {5'd0, carry_flag, dec_flag, irq_mask}, {5'd0, m_p[0], m_p[3], m_p[2]});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
